// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through data cache for the LSQ load port.
// Hits return in one cycle; one outstanding miss on the tagged memory bus.
module dcache_ctrl #(
   parameter int NUM_LINES = 32,
   parameter int IDX_BITS  = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Dcache_rd_mem,
   input  logic        Dcache_wr_mem,
   input  logic [63:0] Dcache_addr,
   input  logic [6:0]  Dcache_pr_idx,
   input  logic [4:0]  Dcache_ar_idx,
   output logic        Dcache_avail,
   input  logic        st_valid,
   input  logic [63:0] st_addr,
   input  logic [63:0] st_value,
   output logic        st_ready,
   output logic        ld_complete,
   output logic [6:0]  ld_pr_idx,
   output logic [4:0]  ld_ar_idx,
   output logic        ld_wr_enable,
   output logic [63:0] ld_value,
   output logic [1:0]  proc2mem_command,
   output logic [63:0] proc2mem_addr,
   output logic [63:0] proc2mem_data,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag
);

   localparam int TAG_BITS = 64 - IDX_BITS - 3;
   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      MISS_REQ,
      MISS_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [63:3]           miss_addr_q, miss_addr_d;
   logic [6:0]            miss_pr_q, miss_pr_d;
   logic [4:0]            miss_ar_q, miss_ar_d;
   logic [3:0]            pend_tag_q, pend_tag_d;
   logic [NUM_LINES-1:0]  valid_q, valid_d;
   logic                  ld_complete_q, ld_complete_d;
   logic [63:0]           ld_value_q, ld_value_d;
   logic [6:0]            ld_pr_q, ld_pr_d;
   logic [4:0]            ld_ar_q, ld_ar_d;

   logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
   logic [63:0]           data_mem [NUM_LINES];

   logic [IDX_BITS-1:0]   ld_idx, st_idx, miss_idx, wr_idx;
   logic [TAG_BITS-1:0]   ld_tag, st_tag, wr_tag;
   logic [63:0]           wr_data;
   logic                  wr_en, wr_fill;
   logic                  idle, ld_hit, st_hit, st_accept, same_blk;
   logic                  unused_ok;

   assign unused_ok = ^{Dcache_wr_mem, Dcache_addr[2:0], st_addr[2:0]};

   assign ld_idx   = Dcache_addr[IDX_BITS+2:3];
   assign ld_tag   = Dcache_addr[63:IDX_BITS+3];
   assign st_idx   = st_addr[IDX_BITS+2:3];
   assign st_tag   = st_addr[63:IDX_BITS+3];
   assign miss_idx = miss_addr_q[IDX_BITS+2:3];

   assign idle      = (state_q == IDLE);
   assign ld_hit    = valid_q[ld_idx] && (tag_mem[ld_idx] == ld_tag);
   assign st_hit    = valid_q[st_idx] && (tag_mem[st_idx] == st_tag);
   assign st_accept = idle && st_valid && (mem2proc_response != 4'd0);
   assign same_blk  = (Dcache_addr[63:3] == st_addr[63:3]);

   assign Dcache_avail = idle;
   assign st_ready     = st_accept;
   assign ld_complete  = ld_complete_q;
   assign ld_wr_enable = ld_complete_q;
   assign ld_value     = ld_value_q;
   assign ld_pr_idx    = ld_pr_q;
   assign ld_ar_idx    = ld_ar_q;

   // Bus drive: a store owns the bus in IDLE, a pending miss in MISS_REQ.
   always_comb begin
      proc2mem_command = CMD_NONE;
      proc2mem_addr    = 64'd0;
      proc2mem_data    = 64'd0;
      case (state_q)
         IDLE: begin
            if (st_valid) begin
               proc2mem_command = CMD_STORE;
               proc2mem_addr    = {st_addr[63:3], 3'b000};
               proc2mem_data    = st_value;
            end
         end
         MISS_REQ: begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = {miss_addr_q, 3'b000};
         end
         default: ;
      endcase
   end

   // Next state: lookup, miss tracking, completion and cache write port.
   always_comb begin
      state_d       = state_q;
      miss_addr_d   = miss_addr_q;
      miss_pr_d     = miss_pr_q;
      miss_ar_d     = miss_ar_q;
      pend_tag_d    = pend_tag_q;
      ld_complete_d = 1'b0;
      ld_value_d    = 64'd0;
      ld_pr_d       = 7'd0;
      ld_ar_d       = 5'd0;
      wr_en         = 1'b0;
      wr_fill       = 1'b0;
      wr_idx        = '0;
      wr_tag        = '0;
      wr_data       = 64'd0;
      case (state_q)
         IDLE: begin
            if (st_accept && st_hit) begin
               wr_en   = 1'b1;
               wr_idx  = st_idx;
               wr_tag  = st_tag;
               wr_data = st_value;
            end
            if (Dcache_rd_mem) begin
               if (ld_hit) begin
                  ld_complete_d = 1'b1;
                  ld_pr_d       = Dcache_pr_idx;
                  ld_ar_d       = Dcache_ar_idx;
                  // a same-cycle store to this block wins over stale data
                  ld_value_d    = (st_accept && same_blk) ?
                                  st_value : data_mem[ld_idx];
               end else begin
                  miss_addr_d = Dcache_addr[63:3];
                  miss_pr_d   = Dcache_pr_idx;
                  miss_ar_d   = Dcache_ar_idx;
                  state_d     = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            if (mem2proc_response != 4'd0) begin
               pend_tag_d = mem2proc_response;
               state_d    = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (pend_tag_q != 4'd0 && mem2proc_tag == pend_tag_q) begin
               wr_en         = 1'b1;
               wr_fill       = 1'b1;
               wr_idx        = miss_idx;
               wr_tag        = miss_addr_q[63:IDX_BITS+3];
               wr_data       = mem2proc_data;
               ld_complete_d = 1'b1;
               ld_value_d    = mem2proc_data;
               ld_pr_d       = miss_pr_q;
               ld_ar_d       = miss_ar_q;
               pend_tag_d    = 4'd0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      valid_d = valid_q;
      if (wr_fill) valid_d[wr_idx] = 1'b1;
   end

   // Control state and completion registers; reset drops any miss.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         miss_addr_q   <= '0;
         miss_pr_q     <= 7'd0;
         miss_ar_q     <= 5'd0;
         pend_tag_q    <= 4'd0;
         valid_q       <= '0;
         ld_complete_q <= 1'b0;
         ld_value_q    <= 64'd0;
         ld_pr_q       <= 7'd0;
         ld_ar_q       <= 5'd0;
      end else begin
         state_q       <= state_d;
         miss_addr_q   <= miss_addr_d;
         miss_pr_q     <= miss_pr_d;
         miss_ar_q     <= miss_ar_d;
         pend_tag_q    <= pend_tag_d;
         valid_q       <= valid_d;
         ld_complete_q <= ld_complete_d;
         ld_value_q    <= ld_value_d;
         ld_pr_q       <= ld_pr_d;
         ld_ar_q       <= ld_ar_d;
      end
   end

   // Tag/data arrays need no reset: the valid bits guard them.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenario bench for dcache_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dcache_ctrl;

   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;
   localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D2 = 64'hA5A5_0000_5A5A_FFFF;
   localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D4 = 64'hBAD0_BAD0_BAD0_BAD0;
   localparam logic [63:0] D5 = 64'h0000_0000_C0DE_0005;

   logic        clock;
   logic        reset;
   logic        Dcache_rd_mem;
   logic        Dcache_wr_mem;
   logic [63:0] Dcache_addr;
   logic [6:0]  Dcache_pr_idx;
   logic [4:0]  Dcache_ar_idx;
   logic        Dcache_avail;
   logic        st_valid;
   logic [63:0] st_addr;
   logic [63:0] st_value;
   logic        st_ready;
   logic        ld_complete;
   logic [6:0]  ld_pr_idx;
   logic [4:0]  ld_ar_idx;
   logic        ld_wr_enable;
   logic [63:0] ld_value;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;

   int n_cmp = 0;
   int n_err = 0;

   dcache_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .Dcache_rd_mem     (Dcache_rd_mem),
      .Dcache_wr_mem     (Dcache_wr_mem),
      .Dcache_addr       (Dcache_addr),
      .Dcache_pr_idx     (Dcache_pr_idx),
      .Dcache_ar_idx     (Dcache_ar_idx),
      .Dcache_avail      (Dcache_avail),
      .st_valid          (st_valid),
      .st_addr           (st_addr),
      .st_value          (st_value),
      .st_ready          (st_ready),
      .ld_complete       (ld_complete),
      .ld_pr_idx         (ld_pr_idx),
      .ld_ar_idx         (ld_ar_idx),
      .ld_wr_enable      (ld_wr_enable),
      .ld_value          (ld_value),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset();
      @(negedge clock);
      #1;
      n_cmp++;
      if (Dcache_avail !== 1'b1) begin
         n_err++; $display("FAIL rst_avail got %b want 1", Dcache_avail);
      end
      n_cmp++;
      if (st_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_st_ready got %b want 0", st_ready);
      end
      n_cmp++;
      if ({ld_complete, ld_wr_enable} !== 2'b00) begin
         n_err++; $display("FAIL rst_complete got %b%b want 00",
                           ld_complete, ld_wr_enable);
      end
      n_cmp++;
      if ({ld_value, ld_pr_idx, ld_ar_idx} !== 76'd0) begin
         n_err++; $display("FAIL rst_ld_out got %h/%0d/%0d want 0/0/0",
                           ld_value, ld_pr_idx, ld_ar_idx);
      end
      n_cmp++;
      if (proc2mem_command !== NONE) begin
         n_err++; $display("FAIL rst_cmd got %0d want 0", proc2mem_command);
      end
      reset = 1'b1;
   endtask

   task automatic test_cold_miss();
      @(negedge clock);
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h1000;
      Dcache_pr_idx = 7'd12; Dcache_ar_idx = 5'd3;
      #1;
      n_cmp++;
      if (Dcache_avail !== 1'b1) begin
         n_err++; $display("FAIL cold_avail0 got %b want 1", Dcache_avail);
      end
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (Dcache_avail !== 1'b0 || proc2mem_command !== LOAD ||
          proc2mem_addr !== 64'h1000) begin
         n_err++; $display("FAIL cold_req got avail=%b cmd=%0d addr=%h want 0/1/1000",
                           Dcache_avail, proc2mem_command, proc2mem_addr);
      end
      mem2proc_response = 4'd5;
      @(negedge clock);
      mem2proc_response = 4'd0;
      #1;
      n_cmp++;
      if (proc2mem_command !== NONE || Dcache_avail !== 1'b0) begin
         n_err++; $display("FAIL cold_wait got cmd=%0d avail=%b want 0/0",
                           proc2mem_command, Dcache_avail);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1;
         n_cmp++;
         if (Dcache_avail !== 1'b0 || ld_complete !== 1'b0) begin
            n_err++; $display("FAIL cold_hold got avail=%b cmp=%b want 0/0",
                              Dcache_avail, ld_complete);
         end
      end
      @(negedge clock);
      mem2proc_tag = 4'd5; mem2proc_data = D1;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0 || Dcache_avail !== 1'b0) begin
         n_err++; $display("FAIL cold_tagcyc got cmp=%b avail=%b want 0/0",
                           ld_complete, Dcache_avail);
      end
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h1000;
      Dcache_pr_idx = 7'd13; Dcache_ar_idx = 5'd4;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_wr_enable !== 1'b1 || ld_value !== D1 ||
          ld_pr_idx !== 7'd12 || ld_ar_idx !== 5'd3) begin
         n_err++; $display("FAIL cold_done got c=%b w=%b v=%h pr=%0d ar=%0d want 1/1/%h/12/3",
                           ld_complete, ld_wr_enable, ld_value, ld_pr_idx, ld_ar_idx, D1);
      end
      n_cmp++;
      if (Dcache_avail !== 1'b1) begin
         n_err++; $display("FAIL cold_avail1 got %b want 1", Dcache_avail);
      end
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_pr_idx !== 7'd13 || ld_value !== D1 ||
          proc2mem_command !== NONE) begin
         n_err++; $display("FAIL fill_rehit got c=%b pr=%0d v=%h cmd=%0d want 1/13/%h/0",
                           ld_complete, ld_pr_idx, ld_value, proc2mem_command, D1);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if ({ld_complete, ld_value, ld_pr_idx, ld_ar_idx} !== 77'd0) begin
         n_err++; $display("FAIL idle_zero got c=%b v=%h pr=%0d ar=%0d want zeros",
                           ld_complete, ld_value, ld_pr_idx, ld_ar_idx);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h1000;
      Dcache_pr_idx = 7'd1; Dcache_ar_idx = 5'd1;
      @(negedge clock);
      Dcache_addr = 64'h1004;
      Dcache_pr_idx = 7'd2; Dcache_ar_idx = 5'd2;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_pr_idx !== 7'd1 || ld_ar_idx !== 5'd1 ||
          ld_value !== D1 || proc2mem_command !== NONE) begin
         n_err++; $display("FAIL b2b_first got c=%b pr=%0d ar=%0d v=%h cmd=%0d",
                           ld_complete, ld_pr_idx, ld_ar_idx, ld_value, proc2mem_command);
      end
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_pr_idx !== 7'd2 || ld_ar_idx !== 5'd2 ||
          ld_value !== D1 || proc2mem_command !== NONE) begin
         n_err++; $display("FAIL b2b_second got c=%b pr=%0d ar=%0d v=%h cmd=%0d",
                           ld_complete, ld_pr_idx, ld_ar_idx, ld_value, proc2mem_command);
      end
      @(negedge clock);
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0) begin
         n_err++; $display("FAIL b2b_end got %b want 0", ld_complete);
      end
   endtask

   task automatic test_reject_retry();
      @(negedge clock);
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h3008;
      Dcache_pr_idx = 7'd20; Dcache_ar_idx = 5'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         Dcache_rd_mem = 1'b0; mem2proc_response = 4'd0;
         #1;
         n_cmp++;
         if (proc2mem_command !== LOAD || proc2mem_addr !== 64'h3008 ||
             Dcache_avail !== 1'b0) begin
            n_err++; $display("FAIL rej_retry%0d got cmd=%0d addr=%h avail=%b want 1/3008/0",
                              i, proc2mem_command, proc2mem_addr, Dcache_avail);
         end
      end
      @(negedge clock);
      st_valid = 1'b1; st_addr = 64'h1000; st_value = 64'h77;
      mem2proc_response = 4'd3;
      #1;
      n_cmp++;
      if (proc2mem_command !== LOAD || st_ready !== 1'b0) begin
         n_err++; $display("FAIL rej_accept got cmd=%0d st_ready=%b want 1/0",
                           proc2mem_command, st_ready);
      end
      @(negedge clock);
      mem2proc_response = 4'd2;
      mem2proc_tag = 4'd7; mem2proc_data = 64'hFFFF;
      #1;
      n_cmp++;
      if (proc2mem_command !== NONE || st_ready !== 1'b0 ||
          Dcache_avail !== 1'b0) begin
         n_err++; $display("FAIL rej_wait got cmd=%0d st_ready=%b avail=%b want 0/0/0",
                           proc2mem_command, st_ready, Dcache_avail);
      end
      @(negedge clock);
      st_valid = 1'b0; mem2proc_response = 4'd0;
      mem2proc_tag = 4'd3; mem2proc_data = D2;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0) begin
         n_err++; $display("FAIL rej_wrongtag got c=%b want 0", ld_complete);
      end
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_value !== D2 || ld_pr_idx !== 7'd20 ||
          ld_ar_idx !== 5'd7) begin
         n_err++; $display("FAIL rej_done got c=%b v=%h pr=%0d ar=%0d want 1/%h/20/7",
                           ld_complete, ld_value, ld_pr_idx, ld_ar_idx, D2);
      end
   endtask

   task automatic test_store_forward();
      @(negedge clock);
      st_valid = 1'b1; st_addr = 64'h1000; st_value = 64'hDEAD;
      mem2proc_response = 4'd2;
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h1000;
      Dcache_pr_idx = 7'd5; Dcache_ar_idx = 5'd4;
      #1;
      n_cmp++;
      if (st_ready !== 1'b1 || proc2mem_command !== STORE ||
          proc2mem_addr !== 64'h1000 || proc2mem_data !== 64'hDEAD) begin
         n_err++; $display("FAIL fwd_bus got rdy=%b cmd=%0d addr=%h data=%h want 1/2/1000/dead",
                           st_ready, proc2mem_command, proc2mem_addr, proc2mem_data);
      end
      @(negedge clock);
      st_valid = 1'b0; mem2proc_response = 4'd0;
      Dcache_pr_idx = 7'd6; Dcache_ar_idx = 5'd5;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_value !== 64'hDEAD || ld_pr_idx !== 7'd5) begin
         n_err++; $display("FAIL fwd_load got c=%b v=%h pr=%0d want 1/dead/5",
                           ld_complete, ld_value, ld_pr_idx);
      end
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_value !== 64'hDEAD || ld_pr_idx !== 7'd6) begin
         n_err++; $display("FAIL fwd_later got c=%b v=%h pr=%0d want 1/dead/6",
                           ld_complete, ld_value, ld_pr_idx);
      end
   endtask

   task automatic test_store_miss();
      @(negedge clock);
      st_valid = 1'b1; st_addr = 64'h2000; st_value = 64'hBEEF;
      mem2proc_response = 4'd0;
      #1;
      n_cmp++;
      if (st_ready !== 1'b0 || proc2mem_command !== STORE ||
          proc2mem_addr !== 64'h2000 || proc2mem_data !== 64'hBEEF) begin
         n_err++; $display("FAIL st_reject got rdy=%b cmd=%0d addr=%h data=%h want 0/2/2000/beef",
                           st_ready, proc2mem_command, proc2mem_addr, proc2mem_data);
      end
      @(negedge clock);
      mem2proc_response = 4'd1;
      #1;
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_err++; $display("FAIL st_accept got %b want 1", st_ready);
      end
      @(negedge clock);
      st_valid = 1'b0; mem2proc_response = 4'd0;
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h2000;
      Dcache_pr_idx = 7'd9; Dcache_ar_idx = 5'd9;
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0 || Dcache_avail !== 1'b0 ||
          proc2mem_command !== LOAD || proc2mem_addr !== 64'h2000) begin
         n_err++; $display("FAIL st_noalloc got c=%b avail=%b cmd=%0d addr=%h want 0/0/1/2000",
                           ld_complete, Dcache_avail, proc2mem_command, proc2mem_addr);
      end
      mem2proc_response = 4'd4;
      @(negedge clock);
      mem2proc_response = 4'd0;
      mem2proc_tag = 4'd4; mem2proc_data = D3;
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_value !== D3 || ld_pr_idx !== 7'd9) begin
         n_err++; $display("FAIL st_fetch got c=%b v=%h pr=%0d want 1/%h/9",
                           ld_complete, ld_value, ld_pr_idx, D3);
      end
   endtask

   task automatic test_reset_mid_miss();
      @(negedge clock);
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h4010;
      Dcache_pr_idx = 7'd30; Dcache_ar_idx = 5'd6;
      @(negedge clock);
      Dcache_rd_mem = 1'b0; mem2proc_response = 4'd6;
      @(negedge clock);
      mem2proc_response = 4'd0;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (Dcache_avail !== 1'b1 || ld_complete !== 1'b0 ||
          proc2mem_command !== NONE) begin
         n_err++; $display("FAIL rmid_async got avail=%b c=%b cmd=%0d want 1/0/0",
                           Dcache_avail, ld_complete, proc2mem_command);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      mem2proc_tag = 4'd6; mem2proc_data = D4;
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0 || Dcache_avail !== 1'b1) begin
         n_err++; $display("FAIL rmid_stale got c=%b avail=%b want 0/1",
                           ld_complete, Dcache_avail);
      end
      Dcache_rd_mem = 1'b1; Dcache_addr = 64'h2000;
      Dcache_pr_idx = 7'd1; Dcache_ar_idx = 5'd1;
      @(negedge clock);
      Dcache_rd_mem = 1'b0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b0 || Dcache_avail !== 1'b0 ||
          proc2mem_command !== LOAD || proc2mem_addr !== 64'h2000) begin
         n_err++; $display("FAIL rmid_invalid got c=%b avail=%b cmd=%0d addr=%h want 0/0/1/2000",
                           ld_complete, Dcache_avail, proc2mem_command, proc2mem_addr);
      end
      mem2proc_response = 4'd1;
      @(negedge clock);
      mem2proc_response = 4'd0;
      mem2proc_tag = 4'd1; mem2proc_data = D5;
      @(negedge clock);
      mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
      #1;
      n_cmp++;
      if (ld_complete !== 1'b1 || ld_value !== D5 || ld_pr_idx !== 7'd1) begin
         n_err++; $display("FAIL rmid_refill got c=%b v=%h pr=%0d want 1/%h/1",
                           ld_complete, ld_value, ld_pr_idx, D5);
      end
   endtask

   initial begin
      reset             = 1'b0;
      Dcache_rd_mem     = 1'b0;
      Dcache_wr_mem     = 1'b0;
      Dcache_addr       = 64'd0;
      Dcache_pr_idx     = 7'd0;
      Dcache_ar_idx     = 5'd0;
      st_valid          = 1'b0;
      st_addr           = 64'd0;
      st_value          = 64'd0;
      mem2proc_response = 4'd0;
      mem2proc_data     = 64'd0;
      mem2proc_tag      = 4'd0;
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_reject_retry();
      test_store_forward();
      test_store_miss();
      test_reset_mid_miss();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
